// File: rtl/kdf_capture_pkg.sv
// rtl/kdf_capture_pkg.sv - shared types and constants for the KDF result capture block
// Purpose: FSM state encoding, frame length, debug-select codes.
// Contents:
//   state_e          IDLE / MEASURE / STREAM / DONE
//   stream_bytes()   frame length in bytes for a given key width
//   STREAM_BYTES     frame length at the default key width
//   DBG_*            sw_i codes for the debug word
package kdf_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STREAM  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int KEY_WIDTH_DEFAULT = 128;
  localparam int CNT_BYTES         = 4;

  // The frame is the key bytes followed by four cycle-count bytes.
  function automatic int stream_bytes(input int key_width);
    return key_width / 8 + CNT_BYTES;
  endfunction

  localparam int STREAM_BYTES = KEY_WIDTH_DEFAULT / 8 + CNT_BYTES;

  localparam logic [1:0] DBG_CYCLES = 2'b00;
  localparam logic [1:0] DBG_KEY_LO = 2'b01;
  localparam logic [1:0] DBG_KEY_HI = 2'b10;
  localparam logic [1:0] DBG_STATUS = 2'b11;

endpackage

// File: rtl/kdf_byte_serializer.sv
// rtl/kdf_byte_serializer.sv - MSB-first byte serializer with valid/ready handshake
// Purpose: loads {key, cycles} into a shift register and emits it one byte per
//          accepted transfer.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear_i       resets the byte index (issued on capture)
//   run_i         owner is in STREAM; raises valid on the first idle cycle
//   key_i, cnt_i  frame contents, sampled when valid rises
//   ready_i       downstream ready
//   byte_o        current byte (stable while valid && !ready)
//   valid_o       registered valid
//   index_o       index of the byte currently presented
//   last_o        final byte accepted this cycle
module kdf_byte_serializer
  import kdf_capture_pkg::*;
#(
  parameter int KEY_WIDTH = 128,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 run_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 ready_i,
  output logic [7:0]           byte_o,
  output logic                 valid_o,
  output logic [7:0]           index_o,
  output logic                 last_o
);

  localparam int         NBYTES   = stream_bytes(KEY_WIDTH);
  localparam int         FRAME_W  = NBYTES * 8;
  localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic [7:0]         index_q, index_d;
  logic               xfer;

  assign xfer = valid_q && ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
    end else begin
      frame_q <= frame_d;
      valid_q <= valid_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    frame_d = frame_q;
    valid_d = valid_q;
    index_d = index_q;
    if (clear_i) begin
      valid_d = 1'b0;
      index_d = '0;
    end else if (xfer) begin
      if (index_q == LAST_IDX) begin
        // index stays on the last byte so the status word shows a full frame
        valid_d = 1'b0;
      end else begin
        frame_d = {frame_q[FRAME_W-9:0], 8'h00};
        index_d = index_q + 8'd1;
      end
    end else if (run_i && !valid_q) begin
      // Frame is loaded on the edge valid rises, one cycle after capture.
      frame_d = {key_i, cnt_i};
      valid_d = 1'b1;
    end
  end

  assign byte_o  = frame_q[FRAME_W-1 -: 8];
  assign valid_o = valid_q;
  assign index_o = index_q;
  assign last_o  = xfer && (index_q == LAST_IDX);

endmodule

// File: rtl/kdf_result_capture.sv
// rtl/kdf_result_capture.sv - KDF latency measurement, key capture and byte streaming
// Purpose: counts cycles from start_i to end_i, latches the derived key, streams
//          {key, cycles} MSB-first and exposes a switch-selected debug word.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   start_i                      measurement start / restart pulse
//   end_i, key_i                 UUT end_signal and derived key
//   sw_i                         debug word select
//   byte_o, byte_valid_o,
//   byte_ready_i                 outgoing byte stream
//   busy_o, done_o, cycles_o     status and captured latency
//   debug_o                      display word
//   timeout_o                    only with KDF_CAPTURE_TIMEOUT_EN
// Optional: KDF_CAPTURE_TIMEOUT_EN adds TIMEOUT_CYCLES and timeout_o.
module kdf_result_capture
  import kdf_capture_pkg::*;
#(
  parameter int KEY_WIDTH = 128,
  parameter int CNT_WIDTH = 32
`ifdef KDF_CAPTURE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 2 ** 24
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 end_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic [1:0]           sw_i,
  output logic [7:0]           byte_o,
  output logic                 byte_valid_o,
  input  logic                 byte_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] cycles_o,
  output logic [31:0]          debug_o
`ifdef KDF_CAPTURE_TIMEOUT_EN
  ,
  output logic                 timeout_o
`endif
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 capture;
  logic                 ser_last;
  logic [7:0]           ser_index;
`ifdef KDF_CAPTURE_TIMEOUT_EN
  logic                 timeout_q, timeout_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cycles_q <= '0;
      key_q    <= '0;
`ifdef KDF_CAPTURE_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      key_q    <= key_d;
`ifdef KDF_CAPTURE_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next state and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    key_d    = key_q;
    capture  = 1'b0;
`ifdef KDF_CAPTURE_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
`ifdef KDF_CAPTURE_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      ST_MEASURE: begin
        // Restart wins over a simultaneous end_i.
        if (start_i) begin
          cnt_d = '0;
`ifdef KDF_CAPTURE_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end else if (end_i) begin
          cycles_d = cnt_q;
          key_d    = key_i;
          capture  = 1'b1;
          state_d  = ST_STREAM;
`ifdef KDF_CAPTURE_TIMEOUT_EN
        end else if (cnt_q >= CNT_WIDTH'(TIMEOUT_CYCLES)) begin
          cycles_d  = '1;
          key_d     = '0;
          capture   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_STREAM;
`endif
        end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STREAM: begin
        if (ser_last) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  kdf_byte_serializer #(
    .KEY_WIDTH (KEY_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .clear_i (capture),
    .run_i   (state_q == ST_STREAM),
    .key_i   (key_q),
    .cnt_i   (cycles_q),
    .ready_i (byte_ready_i),
    .byte_o  (byte_o),
    .valid_o (byte_valid_o),
    .index_o (ser_index),
    .last_o  (ser_last)
  );

  // Outputs
  always_comb begin
    busy_o   = (state_q == ST_MEASURE) || (state_q == ST_STREAM);
    done_o   = (state_q == ST_DONE);
    cycles_o = cycles_q;
    case (sw_i)
      DBG_CYCLES: debug_o = cycles_q[31:0];
      DBG_KEY_LO: debug_o = key_q[31:0];
      DBG_KEY_HI: debug_o = key_q[KEY_WIDTH-1 -: 32];
      DBG_STATUS: debug_o = {state_q, 1'b0, done_o, ser_index, cnt_q[19:0]};
      default:    debug_o = '0;
    endcase
  end

`ifdef KDF_CAPTURE_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

endmodule
